// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: instruction classes as delivered
// by the decoder, the controller state encoding, and default sizing.
package pc_seq_pkg;

    localparam int PC_W_DEF        = 4;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HALT   = 3'd5
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: small LIFO holding return addresses for CALL/RET.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (empties the stack)
//   push, push_data write push_data on top; ignored when full
//   pop             discard the top entry; ignored when empty
//   pop_data        top entry, combinational
//   full, empty     occupancy flags
//   depth           number of valid entries (0..DEPTH)
module ret_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      depth_r;
    logic [AW:0]      depth_m1_s;
    logic [AW-1:0]    top_idx_s;

    assign full       = (depth_r == (AW+1)'(DEPTH));
    assign empty      = (depth_r == '0);
    assign depth      = depth_r;
    // When empty the index wraps; pop_data is then meaningless and unused.
    assign depth_m1_s = depth_r - {{AW{1'b0}}, 1'b1};
    assign top_idx_s  = depth_m1_s[AW-1:0];
    assign pop_data   = mem_r[top_idx_s];

    // Entry storage and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push && !full) begin
            mem_r[depth_r[AW-1:0]] <= push_data;
            depth_r                <= depth_r + {{AW{1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            depth_r <= depth_m1_s;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle FETCH/DECODE/EXEC controller producing the next
// value for the external PC register, with CALL/RET through a return stack.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   run               start/continue request (level)
//   pc_current        PC register value; pc_next is loaded into it every cycle
//   pc_next           next PC (equals pc_current outside EXEC)
//   imem_req/imem_ack instruction fetch handshake (imem_req registered)
//   instr_valid       high in DECODE
//   op_class, alu_zero, target  decoder/ALU inputs, used in EXEC
//   exec_strobe       high in EXEC
//   halted, fault     sticky terminal indications
//   stack_depth       return stack occupancy
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic [PC_W-1:0]               pc_current,
    output logic [PC_W-1:0]               pc_next,
    output logic                          imem_req,
    input  logic                          imem_ack,
    output logic                          instr_valid,
    input  logic [2:0]                    op_class,
    input  logic                          alu_zero,
    input  logic [PC_W-1:0]               target,
    output logic                          exec_strobe,
    output logic                          halted,
    output logic                          fault,
    output logic [$clog2(STACK_DEPTH):0]  stack_depth
);

    seq_state_e      state_r;
    seq_state_e      state_next_s;
    logic            imem_req_r;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] pc_next_s;
    logic [PC_W-1:0] pop_data_s;
    logic            push_s;
    logic            pop_s;
    logic            st_full_s;
    logic            st_empty_s;

    assign pc_inc_s    = pc_current + PC_W'(1);   // wraps modulo 2^PC_W
    assign pc_next     = pc_next_s;
    assign imem_req    = imem_req_r;
    assign instr_valid = (state_r == ST_DECODE);
    assign exec_strobe = (state_r == ST_EXEC);
    assign halted      = (state_r == ST_HALT);
    assign fault       = (state_r == ST_FAULT);

    ret_stack #(
        .WIDTH (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (pc_inc_s),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .full      (st_full_s),
        .empty     (st_empty_s),
        .depth     (stack_depth)
    );

    // State register; imem_req is registered from the next state so it is
    // high throughout FETCH, including its first cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            imem_req_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            imem_req_r <= (state_next_s == ST_FETCH);
        end
    end

    // Next-state, next-PC and stack control.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_current;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (run) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
                case (op_class_e'(op_class))
                    OP_SEQ: begin
                        pc_next_s = pc_inc_s;
                    end
                    OP_BRANCH: begin
                        if (alu_zero) begin
                            pc_next_s = target;
                        end else begin
                            pc_next_s = pc_inc_s;
                        end
                    end
                    OP_JUMP: begin
                        pc_next_s = target;
                    end
                    OP_CALL: begin
                        // Overflow: no push, PC holds, lock up in FAULT.
                        if (st_full_s) begin
                            state_next_s = ST_FAULT;
                        end else begin
                            push_s    = 1'b1;
                            pc_next_s = target;
                        end
                    end
                    OP_RET: begin
                        // Underflow: PC holds, lock up in FAULT.
                        if (st_empty_s) begin
                            state_next_s = ST_FAULT;
                        end else begin
                            pop_s     = 1'b1;
                            pc_next_s = pop_data_s;
                        end
                    end
                    OP_HALT: begin
                        state_next_s = ST_HALT;
                    end
                    default: begin
                        pc_next_s = pc_inc_s;   // unused codes act as SEQ
                    end
                endcase
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       imem_ack;
    logic       alu_zero;
    logic [3:0] pc_reg;
    logic [3:0] pc_next;
    logic [3:0] target;
    logic [2:0] op_class;
    logic       imem_req;
    logic       instr_valid;
    logic       exec_strobe;
    logic       halted;
    logic       fault;
    logic [2:0] stack_depth;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: PC value, return stack as a queue, terminal flags.
    int m_pc;
    int m_stk[$];
    int m_halt;
    int m_fault;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pc_current  (pc_reg),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .op_class    (op_class),
        .alu_zero    (alu_zero),
        .target      (target),
        .exec_strobe (exec_strobe),
        .halted      (halted),
        .fault       (fault),
        .stack_depth (stack_depth)
    );

    always #5 clk = ~clk;

    // External PC register, loads pc_next every cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_reg <= 4'd0;
        else       pc_reg <= pc_next;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0;
        op_class = 3'd0; target = 4'd0; alu_zero = 1'b0;
        tick();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_iv", instr_valid, 1'b0);
        chk("rst_ex", exec_strobe, 1'b0);
        chk("rst_halt", halted, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_depth", stack_depth, 3'd0);
        chk("rst_pcnext", pc_next, pc_reg);
        reset = 1'b0;
        m_pc = 0; m_stk.delete(); m_halt = 0; m_fault = 0;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
    endtask

    // One full instruction, from the first FETCH cycle to the cycle after EXEC.
    task automatic do_instr(input int op, input int tgt, input int az, input int stall, input int nrun);
        int inc;
        int e;
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_noiv", instr_valid, 1'b0);
        imem_ack = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_req", imem_req, 1'b1);
            chk("stall_noiv", instr_valid, 1'b0);
            chk("stall_pc", pc_reg, m_pc);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'($urandom_range(0, 1));   // must be ignored outside FETCH
        chk("dec_iv", instr_valid, 1'b1);
        chk("dec_req", imem_req, 1'b0);
        chk("dec_ex", exec_strobe, 1'b0);
        chk("dec_pcnext", pc_next, pc_reg);
        op_class = 3'(op); target = 4'(tgt); alu_zero = 1'(az); run = 1'(nrun);
        tick();
        imem_ack = 1'b0;
        chk("exec_strobe", exec_strobe, 1'b1);
        chk("exec_iv", instr_valid, 1'b0);
        inc = (m_pc + 1) % 16;
        case (op)
            1: e = (az != 0) ? tgt : inc;
            2: e = tgt;
            3: if (m_stk.size() == 4) begin e = m_pc; m_fault = 1; end
               else begin m_stk.push_back(inc); e = tgt; end
            4: if (m_stk.size() == 0) begin e = m_pc; m_fault = 1; end
               else e = m_stk.pop_back();
            5: begin e = m_pc; m_halt = 1; end
            default: e = inc;
        endcase
        chk("exec_pcnext", pc_next, e);
        m_pc = e;
        tick();
        chk("post_pc", pc_reg, m_pc);
        chk("post_depth", stack_depth, m_stk.size());
        chk("post_halt", halted, m_halt);
        chk("post_fault", fault, m_fault);
        chk("post_ex", exec_strobe, 1'b0);
        chk("post_req", imem_req, (nrun != 0 && m_halt == 0 && m_fault == 0) ? 1 : 0);
        if (m_halt == 0 && m_fault == 0 && nrun == 0) begin
            tick();
            chk("idle_req", imem_req, 1'b0);
            chk("idle_pc", pc_reg, m_pc);
            run = 1'b1;
            tick();
        end
    endtask

    // Terminal states must ignore run and ack and hold the PC.
    task automatic hold_check(input int n);
        run = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("term_req", imem_req, 1'b0);
            chk("term_iv", instr_valid, 1'b0);
            chk("term_pc", pc_reg, m_pc);
            chk("term_halt", halted, m_halt);
            chk("term_fault", fault, m_fault);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        int op;
        @(negedge clk);
        do_reset();
        start();

        // Sequential run through wrap, with a 4-cycle fetch stall at PC=2.
        for (int i = 0; i < 16; i++)
            do_instr(0, $urandom_range(0, 15), $urandom_range(0, 1), (m_pc == 2) ? 4 : 0, 1);
        chk("wrap_pc", pc_reg, 4'd0);

        // Branch taken / not taken from PC=5.
        do_instr(2, 5, 0, 0, 1);
        do_instr(1, 12, 1, 0, 1);
        chk("br_taken", pc_reg, 4'd12);
        do_instr(2, 5, 0, 0, 1);
        do_instr(1, 12, 0, 0, 1);
        chk("br_not_taken", pc_reg, 4'd6);

        // Call / return from PC=3.
        do_instr(2, 3, 0, 0, 1);
        do_instr(3, 9, 0, 0, 1);
        chk("call_pc", pc_reg, 4'd9);
        do_instr(4, 0, 0, 0, 1);
        chk("ret_pc", pc_reg, 4'd4);

        // Overflow on the fifth nested call.
        for (int i = 0; i < 5; i++) do_instr(3, 4 * i + 1, 0, 0, 1);
        chk("ovf_fault", fault, 1'b1);
        chk("ovf_depth", stack_depth, 3'd4);
        hold_check(6);

        // Underflow.
        do_reset();
        start();
        do_instr(4, 0, 0, 0, 1);
        chk("unf_fault", fault, 1'b1);
        hold_check(6);

        // Halt at PC=7.
        do_reset();
        start();
        do_instr(2, 7, 0, 0, 1);
        do_instr(5, 0, 0, 0, 1);
        chk("halt_pc", pc_reg, 4'd7);
        hold_check(10);

        // Reset asserted mid-FETCH clears imem_req at once.
        do_reset();
        start();
        chk("mf_req_before", imem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("mf_req_async", imem_req, 1'b0);
        @(negedge clk);
        reset = 1'b0; run = 1'b0;
        chk("mf_idle_req", imem_req, 1'b0);
        tick();
        chk("mf_idle_hold", imem_req, 1'b0);
        m_pc = 0; m_stk.delete(); m_halt = 0; m_fault = 0;
        start();

        // Randomized instruction stream against the model.
        for (int i = 0; i < 250; i++) begin
            if (m_halt != 0 || m_fault != 0) begin
                do_reset();
                start();
            end
            op = $urandom_range(0, 7);
            if (op == 5 && $urandom_range(0, 3) != 0) op = 3;
            do_instr(op, $urandom_range(0, 15), $urandom_range(0, 1),
                     $urandom_range(0, 3), ($urandom_range(0, 4) != 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
